axi_lite_mem_slave: RTL and testbench

AXI-lite responder that serves the core's instruction-memory and data-memory master ports. It holds a word-addressed, byte-writable 32-bit memory. Writes are accepted through independent AW and W channels and acknowledged on B. Reads are accepted on AR and return data on R with one cycle of latency. Two instances sit on the core's `*_im` and `*_dm` port groups.

---
 rtl/axi_lite_pkg.sv | 19 +
 rtl/axi_mem_array.sv | 53 +++++
 rtl/axi_lite_mem_slave.sv | 196 +++++++++++++++++++
 tb/tb_axi_lite_mem_slave.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI-lite memory responder.
//   RESP_OKAY / RESP_ERR : one-bit response codes used on bresp / rresp
//   STRB_W / DATA_W      : byte-strobe width and data width of the memory word
//   wr_state_t           : write-channel handshake states
package axi_lite_pkg;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  localparam int STRB_W = 4;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

endpackage

// File: rtl/axi_mem_array.sv
// Word-addressed, byte-writable storage for the AXI-lite responder.
//   clk, reset      : rising-edge clock, synchronous active-low reset (read register only)
//   we/waddr/wdata/wstrb : byte-enable write port, bit i of wstrb writes byte i
//   re/rzero/raddr  : synchronous read; rzero loads zero instead of memory data
//   rdata           : registered read data, holds its value while re is low
// Storage contents are never reset. A read and a write to the same word in
// the same cycle return the pre-write contents.
module axi_mem_array
  import axi_lite_pkg::*;
#(
  parameter int DEPTH     = 4096,
  parameter int IDX_W     = 12,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              re,
  input  logic              rzero,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-enable write port.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered read port; nonblocking semantics give read-first on collisions.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata <= {DATA_W{1'b0}};
    end else if (re) begin
      if (rzero) begin
        rdata <= {DATA_W{1'b0}};
      end else begin
        rdata <= mem[raddr];
      end
    end
  end

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI-lite responder in front of a byte-writable 32-bit word memory.
//   clk, reset            : rising-edge clock, synchronous active-low reset
//   aw*/w*/b*             : write address, write data and write response channels
//   ar*/r*                : read address and read data channels
//   awaddr/araddr         : word index; indexes >= DEPTH answer with RESP_ERR
//   awprot/arprot         : accepted and ignored
// Writes accept AW and W in either order, commit once both halves are known,
// then hold bvalid until bready. Reads return data one cycle after AR.
module axi_lite_mem_slave
  import axi_lite_pkg::*;
#(
  parameter int DEPTH     = 4096,
  parameter int ADDR_W    = 12,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [2:0]        awprot,
  input  logic              wvalid,
  output logic              wready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  output logic              bvalid,
  input  logic              bready,
  output logic              bresp,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [2:0]        arprot,
  output logic              rvalid,
  input  logic              rready,
  output logic [31:0]       rdata,
  output logic              rresp
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_L);
  endfunction

  wr_state_t         state_r;
  wr_state_t         state_nxt_s;
  logic              alive_r;    // set once reset has been sampled high
  logic              live_s;
  logic              aw_held_r;  // in W_WAIT: 1 = AW latched, 0 = W latched
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [3:0]        wstrb_r;
  logic              bresp_r;
  logic              commit_s;
  logic [ADDR_W-1:0] cw_addr_s;
  logic [31:0]       cw_data_s;
  logic [3:0]        cw_strb_s;
  logic              ar_hs_s;
  logic              rvalid_r;
  logic              rresp_r;
  logic              unused_prot;

  assign unused_prot = ^{awprot, arprot};

  // Readies are held low in reset and for the first cycle until reset is seen high.
  assign live_s = reset & alive_r;

  // Write FSM next state, channel readies and the committed write beat.
  always_comb begin
    state_nxt_s = state_r;
    awready     = 1'b0;
    wready      = 1'b0;
    commit_s    = 1'b0;
    cw_addr_s   = awaddr;
    cw_data_s   = wdata;
    cw_strb_s   = wstrb;
    case (state_r)
      W_IDLE: begin
        awready = live_s;
        wready  = live_s;
        if (live_s && awvalid && wvalid) begin
          commit_s    = 1'b1;
          state_nxt_s = W_RESP;
        end else if (live_s && (awvalid || wvalid)) begin
          state_nxt_s = W_WAIT;
        end else begin
          state_nxt_s = W_IDLE;
        end
      end
      W_WAIT: begin
        if (aw_held_r) begin
          wready    = live_s;
          cw_addr_s = addr_r;
          if (live_s && wvalid) begin
            commit_s    = 1'b1;
            state_nxt_s = W_RESP;
          end else begin
            state_nxt_s = W_WAIT;
          end
        end else begin
          awready   = live_s;
          cw_data_s = wdata_r;
          cw_strb_s = wstrb_r;
          if (live_s && awvalid) begin
            commit_s    = 1'b1;
            state_nxt_s = W_RESP;
          end else begin
            state_nxt_s = W_WAIT;
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          state_nxt_s = W_IDLE;
        end else begin
          state_nxt_s = W_RESP;
        end
      end
      default: begin
        state_nxt_s = W_IDLE;
      end
    endcase
  end

  // Write FSM state, latched half-beat and write response register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= W_IDLE;
      alive_r   <= 1'b0;
      aw_held_r <= 1'b0;
      addr_r    <= {ADDR_W{1'b0}};
      wdata_r   <= 32'h0000_0000;
      wstrb_r   <= 4'h0;
      bresp_r   <= RESP_OKAY;
    end else begin
      state_r <= state_nxt_s;
      alive_r <= 1'b1;
      if (awvalid && awready) begin
        addr_r <= awaddr;
      end
      if (wvalid && wready) begin
        wdata_r <= wdata;
        wstrb_r <= wstrb;
      end
      // Only meaningful when exactly one channel handshakes out of W_IDLE.
      if (state_r == W_IDLE) begin
        aw_held_r <= awvalid;
      end
      if (commit_s) begin
        bresp_r <= in_range(cw_addr_s) ? RESP_OKAY : RESP_ERR;
      end
    end
  end

  assign bvalid = (state_r == W_RESP);
  assign bresp  = bresp_r;

  // A new read may be accepted whenever the output slot is empty or draining.
  assign arready = live_s & (~rvalid_r | rready);
  assign ar_hs_s = arvalid & arready;

  // Read response valid and error flag; the data itself is held in the array.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rvalid_r <= 1'b0;
      rresp_r  <= RESP_OKAY;
    end else if (ar_hs_s) begin
      rvalid_r <= 1'b1;
      rresp_r  <= in_range(araddr) ? RESP_OKAY : RESP_ERR;
    end else if (rready) begin
      rvalid_r <= 1'b0;
    end
  end

  assign rvalid = rvalid_r;
  assign rresp  = rresp_r;

  axi_mem_array #(
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W),
    .INIT_FILE (INIT_FILE)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (commit_s & in_range(cw_addr_s)),
    .waddr (cw_addr_s[IDX_W-1:0]),
    .wdata (cw_data_s),
    .wstrb (cw_strb_s),
    .re    (ar_hs_s),
    .rzero (~in_range(araddr)),
    .raddr (araddr[IDX_W-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Scoreboard bench for axi_lite_mem_slave (DEPTH = 1024, 12-bit word index).
// Stimulus pushes expected B/R responses computed from a word-array model;
// a negedge monitor pops and compares whenever a response handshakes.
module tb_axi_lite_mem_slave;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        awvalid, awready;
  logic [11:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready, bresp;
  logic        arvalid, arready;
  logic [11:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic        rresp;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model_mem [DEPTH];
  logic        exp_b [$];
  logic [32:0] exp_r [$];
  logic [11:0] rd_list [4];

  logic        b_stall_prev = 1'b0;
  logic        b_prev = 1'b0;
  logic        r_stall_prev = 1'b0;
  logic [32:0] r_prev = 33'h0;

  axi_lite_mem_slave #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected read response: {rresp, rdata}.
  function automatic logic [32:0] model_read(input logic [11:0] a);
    if (a >= 12'(DEPTH)) return {1'b1, 32'h0};
    return {1'b0, model_mem[a[9:0]]};
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a >= 12'(DEPTH)) begin
      exp_b.push_back(1'b1);
    end else begin
      exp_b.push_back(1'b0);
      for (int i = 0; i < 4; i++)
        if (s[i]) model_mem[a[9:0]][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  function automatic logic [11:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 12'($urandom_range(1024, 4095));
    return 12'($urandom_range(0, 63));
  endfunction

  // One write; AW and W each start after their own delay (in cycles).
  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    int cyc = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      awaddr  = addr;
      wvalid  = !w_done && (cyc >= w_dly);
      wdata   = data;
      wstrb   = strb;
      @(negedge clk);
      if (aw_done && !w_done) check("wait_awready_low", awready, 0);
      if (w_done && !aw_done) check("wait_wready_low", wready, 0);
      if (awvalid && awready) aw_done = 1'b1;
      if (wvalid && wready) w_done = 1'b1;
      if (aw_done && w_done) model_write(addr, data, strb);
      @(posedge clk); #1;
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (!(aw_done && w_done)) check("write_timeout", cyc, 0);
  endtask

  // Issue n reads from rd_list back to back; rready follows rr_pat per cycle.
  task automatic read_burst(input int n, input logic [15:0] rr_pat, output int cycles);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < 50) begin
      arvalid = 1'b1;
      araddr  = rd_list[idx];
      rready  = rr_pat[cyc % 16];
      @(negedge clk);
      if (arready) begin
        exp_r.push_back(model_read(rd_list[idx]));
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    arvalid = 1'b0;
    cycles  = cyc;
    if (idx < n) check("read_timeout", idx, n);
  endtask

  // Wait for all outstanding responses, optionally with random ready backpressure.
  task automatic drain(input bit rnd);
    int cyc = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && cyc < 60) begin
      bready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      cyc++;
    end
    if (exp_b.size() != 0 || exp_r.size() != 0) begin
      check("drain_timeout", exp_b.size() + exp_r.size(), 0);
      exp_b.delete();
      exp_r.delete();
    end
    bready = 1'b1;
    rready = 1'b1;
  endtask

  // Response monitor: scoreboard compare on handshake plus hold-while-stalled checks.
  always @(negedge clk) begin
    if (!reset) begin
      b_stall_prev = 1'b0;
      r_stall_prev = 1'b0;
    end else begin
      if (b_stall_prev) begin
        check("b_hold_valid", bvalid, 1);
        check("b_hold_resp", bresp, b_prev);
      end
      if (bvalid) begin
        if (exp_b.size() == 0) check("b_unexpected", bvalid, 0);
        else if (bready) check("bresp", bresp, exp_b.pop_front());
      end
      b_stall_prev = bvalid && !bready;
      b_prev       = bresp;

      if (r_stall_prev) begin
        check("r_hold_valid", rvalid, 1);
        check("r_hold_data", {rresp, rdata}, r_prev);
      end
      if (rvalid) begin
        if (exp_r.size() == 0) check("r_unexpected", rvalid, 0);
        else if (rready) check("rresp_rdata", {rresp, rdata}, exp_r.pop_front());
        else check("r_stall_arready", arready, 0);
      end
      r_stall_prev = rvalid && !rready;
      r_prev       = {rresp, rdata};
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    reset = 1'b0;
    awvalid = 1'b0; awaddr = 12'h0; awprot = 3'd0;
    wvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0;
    bready = 1'b0;
    arvalid = 1'b0; araddr = 12'h0; arprot = 3'd0;
    rready = 1'b0;

    // Reset held for three cycles.
    repeat (3) begin
      @(negedge clk);
      check("rst_awready", awready, 0);
      check("rst_wready", wready, 0);
      check("rst_arready", arready, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_bresp_rresp", {bresp, rresp}, 0);
      check("rst_rdata", rdata, 0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_readies", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;

    // Give the first 64 words known contents.
    for (int a = 0; a < 64; a++) begin
      axi_write(12'(a), $urandom, 4'hF, 0, 0);
      drain(0);
    end

    // Simultaneous AW/W, one-cycle B, read back.
    bready = 1'b1;
    axi_write(12'h005, 32'hDEADBEEF, 4'hF, 0, 0);
    @(negedge clk);
    check("b_first_cycle", bvalid, 1);
    @(negedge clk);
    check("b_second_cycle", bvalid, 0);
    @(posedge clk); #1;
    drain(0);
    rd_list[0] = 12'h005;
    read_burst(1, 16'hFFFF, cycles);
    drain(0);

    // W three cycles ahead of AW, bready held low.
    bready = 1'b0;
    axi_write(12'h005, 32'h000000AA, 4'b0001, 3, 0);
    repeat (4) begin
      @(negedge clk);
      check("bstall_bvalid", bvalid, 1);
      check("bstall_readies", {awready, wready}, 2'b00);
    end
    @(posedge clk); #1;
    drain(0);
    rd_list[0] = 12'h005;
    read_burst(1, 16'hFFFF, cycles);
    drain(0);

    // Back-to-back reads, one accepted per cycle.
    rd_list[0] = 12'h000; rd_list[1] = 12'h001; rd_list[2] = 12'h002;
    read_burst(3, 16'hFFFF, cycles);
    check("b2b_accept_cycles", cycles, 3);
    drain(0);

    // Reads with rready dropped on the second response.
    read_burst(3, 16'hFFF3, cycles);
    drain(0);

    // Out-of-range write and read; word 0 stays intact.
    axi_write(12'h400, 32'h12345678, 4'hF, 0, 0);
    drain(0);
    rd_list[0] = 12'h400; rd_list[1] = 12'h000;
    read_burst(2, 16'hFFFF, cycles);
    drain(0);

    // Zero-strobe write is an OKAY no-op.
    axi_write(12'h003, 32'hFFFFFFFF, 4'h0, 1, 0);
    drain(0);
    rd_list[0] = 12'h003;
    read_burst(1, 16'hFFFF, cycles);
    drain(0);

    // Same-cycle read and write of one word: read-first.
    axi_write(12'h010, 32'h11111111, 4'hF, 0, 0);
    drain(0);
    awvalid = 1'b1; awaddr = 12'h010;
    wvalid = 1'b1; wdata = 32'h22222222; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 12'h010;
    @(negedge clk);
    check("coll_readies", {awready, wready, arready}, 3'b111);
    exp_r.push_back(model_read(12'h010));
    model_write(12'h010, 32'h22222222, 4'hF);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    drain(0);
    rd_list[0] = 12'h010;
    read_burst(1, 16'hFFFF, cycles);
    drain(0);

    // Randomised traffic with random backpressure.
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        axi_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 2), $urandom_range(0, 2));
      end else begin
        int n;
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) rd_list[i] = rand_addr();
        read_burst(n, 16'($urandom) | 16'h0101, cycles);
      end
      drain(1);
    end

    // Reset while waiting for W: the latched AW is discarded.
    awvalid = 1'b1; awaddr = 12'h020;
    @(negedge clk);
    check("wwait_aw_accept", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    check("wwait_readies", {awready, wready}, 2'b01);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("midrst_readies", {awready, wready, arready}, 3'b000);
      check("midrst_valids", {bvalid, rvalid}, 2'b00);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    repeat (3) begin
      @(negedge clk);
      check("after_rst_idle", {awready, wready, bvalid}, 3'b110);
    end
    @(posedge clk); #1;
    rd_list[0] = 12'h020;
    read_burst(1, 16'hFFFF, cycles);
    drain(0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
